// File: rtl/led_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl_if
//   Control and LED-drive bundle between board-status logic and the LED
//   pattern generator.
//   Signals:
//     enable     1         pattern runs when 1, LEDs dark when 0
//     mode       2         00 off, 01 blink, 10 alternate, 11 running
//     period_ms  PERIOD_W  half-period in ticks (0 behaves as 1)
//     led        N_LED     LED drive, 1 = on
//     step_o     1         one-cycle pulse on each pattern step
//   Modports:
//     master  status logic side (drives config, observes LEDs)
//     slave   pattern generator side
// ---------------------------------------------------------------------------
interface led_pattern_ctrl_if #(
  parameter int N_LED    = 4,
  parameter int PERIOD_W = 16
);
  logic                enable;
  logic [1:0]          mode;
  logic [PERIOD_W-1:0] period_ms;
  logic [N_LED-1:0]    led;
  logic                step_o;

  modport master (
    output enable,
    output mode,
    output period_ms,
    input  led,
    input  step_o
  );

  modport slave (
    input  enable,
    input  mode,
    input  period_ms,
    output led,
    output step_o
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//   Multi-channel LED pattern generator. A prescaler produces a tick every
//   TICK_CYCLES clocks; a tick counter produces a pattern step every
//   period_q ticks. Each step toggles the phase bit and rotates a one-hot
//   ring; the LED outputs decode phase/ring according to the latched mode.
//   Ports:
//     sys_clk  in   system clock
//     rst_n    in   asynchronous active-low reset
//     bus      slave modport of led_pattern_ctrl_if
//                (enable/mode/period_ms in, led/step_o out, outputs registered)
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
  parameter int N_LED       = 4,
  parameter int TICK_CYCLES = 50000,
  parameter int PERIOD_W    = 16
) (
  input logic                sys_clk,
  input logic                rst_n,
  led_pattern_ctrl_if.slave  bus
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PRE_W-1:0]    PRE_ZERO   = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]    PRE_ONE    = PRE_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ZERO   = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] PER_ONE    = PERIOD_W'(1);
  localparam logic [N_LED-1:0]    LED_ZERO   = {N_LED{1'b0}};
  localparam logic [N_LED-1:0]    LED_ONES   = {N_LED{1'b1}};
  localparam logic [N_LED-1:0]    RING_INIT  = {{(N_LED-1){1'b0}}, 1'b1};

  // Even-index channels set: the phase-0 pattern of alternate mode.
  function automatic logic [N_LED-1:0] even_mask();
    logic [N_LED-1:0] m;
    m = LED_ZERO;
    for (int i = 0; i < N_LED; i++) begin
      m[i] = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  localparam logic [N_LED-1:0] EVEN_MASK = even_mask();

  // LED decode of a (mode, phase, ring) state.
  function automatic logic [N_LED-1:0] decode_led(
    input logic [1:0]       m,
    input logic             ph,
    input logic [N_LED-1:0] rg
  );
    logic [N_LED-1:0] v;
    case (m)
      2'b00:   v = LED_ZERO;
      2'b01:   v = ph ? LED_ONES : LED_ZERO;
      2'b10:   v = ph ? ~EVEN_MASK : EVEN_MASK;
      2'b11:   v = rg;
      default: v = LED_ZERO;
    endcase
    return v;
  endfunction

  logic [PRE_W-1:0]    pre_cnt_r,  pre_cnt_s;
  logic [PERIOD_W-1:0] ms_cnt_r,   ms_cnt_s;
  logic                phase_r,    phase_s;
  logic [N_LED-1:0]    ring_r,     ring_s;
  logic [1:0]          mode_q_r,   mode_q_s;
  logic [PERIOD_W-1:0] period_q_r, period_q_s;
  logic [N_LED-1:0]    led_r,      led_s;
  logic                step_r,     step_s;

  logic                tick_s;
  logic                step_now_s;
  logic [PERIOD_W-1:0] period_eff_s;

  // Tick/step detection and zero-period saturation of the requested period.
  always_comb begin
    tick_s       = (pre_cnt_r == PRE_LAST);
    step_now_s   = tick_s && (ms_cnt_r == (period_q_r - PER_ONE));
    period_eff_s = (bus.period_ms == PER_ZERO) ? PER_ONE : bus.period_ms;
  end

  // Next-state: idle clears everything and tracks config; run advances the
  // counters and only re-latches config on a step so a change never splits
  // a half-period.
  always_comb begin
    pre_cnt_s  = pre_cnt_r;
    ms_cnt_s   = ms_cnt_r;
    phase_s    = phase_r;
    ring_s     = ring_r;
    mode_q_s   = mode_q_r;
    period_q_s = period_q_r;
    led_s      = LED_ZERO;
    step_s     = 1'b0;

    if (!bus.enable) begin
      pre_cnt_s  = PRE_ZERO;
      ms_cnt_s   = PER_ZERO;
      phase_s    = 1'b0;
      ring_s     = RING_INIT;
      mode_q_s   = bus.mode;
      period_q_s = period_eff_s;
      led_s      = LED_ZERO;
      step_s     = 1'b0;
    end else begin
      pre_cnt_s = tick_s ? PRE_ZERO : (pre_cnt_r + PRE_ONE);

      if (tick_s) begin
        ms_cnt_s = step_now_s ? PER_ZERO : (ms_cnt_r + PER_ONE);
      end else begin
        ms_cnt_s = ms_cnt_r;
      end

      if (step_now_s) begin
        phase_s    = ~phase_r;
        ring_s     = {ring_r[N_LED-2:0], ring_r[N_LED-1]};
        mode_q_s   = bus.mode;
        period_q_s = period_eff_s;
        step_s     = 1'b1;
      end else begin
        step_s     = 1'b0;
      end

      // Decode from next-state values so LEDs change on the step edge itself.
      led_s = decode_led(mode_q_s, phase_s, ring_s);
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r  <= PRE_ZERO;
      ms_cnt_r   <= PER_ZERO;
      phase_r    <= 1'b0;
      ring_r     <= RING_INIT;
      mode_q_r   <= 2'b00;
      period_q_r <= PER_ONE;
      led_r      <= LED_ZERO;
      step_r     <= 1'b0;
    end else begin
      pre_cnt_r  <= pre_cnt_s;
      ms_cnt_r   <= ms_cnt_s;
      phase_r    <= phase_s;
      ring_r     <= ring_s;
      mode_q_r   <= mode_q_s;
      period_q_r <= period_q_s;
      led_r      <= led_s;
      step_r     <= step_s;
    end
  end

  assign bus.led    = led_r;
  assign bus.step_o = step_r;

endmodule
